// File: rtl/fir_pkg.sv
// Shared definitions for the serial 16-tap FIR controller: default sizes,
// controller state encoding and the reset-time coefficient rule.
package fir_pkg;

    localparam int unsigned FIR_TAPS = 16;
    localparam int unsigned FIR_DW   = 16;
    localparam int unsigned FIR_CW   = 16;

    // Accumulator wide enough that TAPS full-scale products never overflow
    function automatic int unsigned acc_width(int unsigned dw, int unsigned cw,
                                              int unsigned taps);
        return dw + cw + $clog2(taps);
    endfunction

    localparam int unsigned FIR_ACC_W = acc_width(FIR_DW, FIR_CW, FIR_TAPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    // Coefficient bank contents after reset: coef[k] = k+1
    function automatic int unsigned default_coef(int unsigned k);
        return k + 1;
    endfunction

endpackage

// File: rtl/fir_sample_buf.sv
// TAPS x DW circular sample store: one write port, one combinational read port
// addressed relative to the newest sample, synchronous clear.
module fir_sample_buf
    import fir_pkg::*;
#(
    parameter int unsigned TAPS = FIR_TAPS,
    parameter int unsigned DW   = FIR_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [$clog2(TAPS)-1:0]  waddr_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic [$clog2(TAPS)-1:0]  base_i,
    input  logic [$clog2(TAPS)-1:0]  k_i,
    output logic [DW-1:0]            rdata_o
);

    localparam int unsigned AW = $clog2(TAPS);

    logic [DW-1:0] mem_q [TAPS];
    logic [AW-1:0] idx_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(TAPS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // TAPS is a power of two, so AW-bit wraparound gives the modulo for free
    assign idx_c   = base_i - k_i;
    assign rdata_o = mem_q[idx_c];

endmodule

// File: rtl/fir_serial_ctrl.sv
// Time-multiplexed FIR: one multiplier/accumulator walks all taps serially,
// with valid/ready sample input, valid/ready result output and a writable coefficient bank.
module fir_serial_ctrl
    import fir_pkg::*;
#(
    parameter int unsigned TAPS      = FIR_TAPS,
    parameter int unsigned DW        = FIR_DW,
    parameter int unsigned CW        = FIR_CW,
    parameter int unsigned OUT_SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DW-1:0]            data_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DW-1:0]            data_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [CW-1:0]            coef_data,
    output logic                     coef_err,
    output logic                     sat
);

    localparam int unsigned KW    = $clog2(TAPS);
    localparam int unsigned PW    = DW + CW;
    localparam int unsigned ACC_W = acc_width(DW, CW, TAPS);

    state_e          state_q;
    logic [KW-1:0]   wp_q;
    logic [KW-1:0]   base_q;
    logic [KW-1:0]   k_q;
    logic [ACC_W-1:0] acc_q;
    logic [CW-1:0]   coef_q [TAPS];
    logic [DW-1:0]   data_out_q;
    logic            out_valid_q;
    logic            sat_q;
    logic            coef_err_q;

    logic            accept_c;
    logic [DW-1:0]   buf_rd_c;
    logic [PW-1:0]   prod_c;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] shifted_c;
    logic            sat_d;
    logic [DW-1:0]   data_out_d;

    // Sample acceptance; coefficient writes win over samples in IDLE
    assign in_ready = rst && (state_q == IDLE) && !coef_we;
    assign accept_c = in_valid && in_ready;

    fir_sample_buf #(
        .TAPS (TAPS),
        .DW   (DW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .we_i    (accept_c),
        .waddr_i (wp_q),
        .wdata_i (data_in),
        .base_i  (base_q),
        .k_i     (k_q),
        .rdata_o (buf_rd_c)
    );

    // Single tap product, running sum and output scaling/saturation
    always_comb begin
        prod_c     = PW'(buf_rd_c) * PW'(coef_q[k_q]);
        acc_d      = acc_q + ACC_W'(prod_c);
        shifted_c  = acc_d >> OUT_SHIFT;
        sat_d      = |shifted_c[ACC_W-1:DW];
        data_out_d = sat_d ? {DW{1'b1}} : shifted_c[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            wp_q        <= '0;
            base_q      <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            coef_err_q  <= 1'b0;
            for (int i = 0; i < int'(TAPS); i++) begin
                coef_q[i] <= CW'(default_coef(i));
            end
        end else begin
            coef_err_q <= coef_we && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (coef_we) begin
                        coef_q[coef_addr] <= coef_data;
                    end else if (in_valid) begin
                        base_q  <= wp_q;
                        wp_q    <= wp_q + KW'(1);
                        acc_q   <= '0;
                        k_q     <= '0;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + KW'(1);
                    // Last tap: capture the scaled result straight from the final sum
                    if (k_q == KW'(TAPS - 1)) begin
                        data_out_q  <= data_out_d;
                        sat_q       <= sat_d;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign sat       = sat_q;
    assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_fir_serial_ctrl.sv
// Directed + randomized bench for fir_serial_ctrl against a convolution model;
// a second instance with OUT_SHIFT=36 runs on the same stimulus.
module tb_fir_serial_ctrl;

    localparam int unsigned TAPS = 16;
    localparam int unsigned DW   = 16;
    localparam int unsigned CW   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          coef_we = 1'b0;
    logic [3:0]    coef_addr = '0;
    logic [CW-1:0] coef_data = '0;

    logic          in_ready, out_valid, coef_err, sat;
    logic [DW-1:0] data_out;
    logic          in_ready2, out_valid2, coef_err2, sat2;
    logic [DW-1:0] data_out2;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    longint unsigned xh[$];
    longint unsigned cm[16];
    int unsigned     last_acc = 0;
    bit              prev_b2b = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_serial_ctrl #(.TAPS(TAPS), .DW(DW), .CW(CW), .OUT_SHIFT(0)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
        .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid),
        .out_ready(out_ready), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_err(coef_err), .sat(sat)
    );

    fir_serial_ctrl #(.TAPS(TAPS), .DW(DW), .CW(CW), .OUT_SHIFT(36)) dut2 (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
        .in_ready(in_ready2), .data_out(data_out2), .out_valid(out_valid2),
        .out_ready(out_ready), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_err(coef_err2), .sat(sat2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // y[n] = sum_k coef[k]*x[n-k] over every sample accepted since reset
    function automatic longint unsigned model_y();
        longint unsigned y = 0;
        int n = xh.size() - 1;
        for (int k = 0; k < int'(TAPS); k++) begin
            if (n - k >= 0) y += cm[k] * xh[n - k];
        end
        return y;
    endfunction

    function automatic longint unsigned scaled(input longint unsigned y, input int sh);
        longint unsigned s = y >> sh;
        return (s > 64'hFFFF) ? 64'hFFFF : s;
    endfunction

    task automatic model_reset();
        xh.delete();
        for (int i = 0; i < 16; i++) cm[i] = longint'(i + 1);
    endtask

    task automatic do_reset();
        rst = 1'b0; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_sat", 64'(sat), 64'd0);
        chk("rst_coef_err", 64'(coef_err), 64'd0);
        rst = 1'b1;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        model_reset();
        prev_b2b = 1'b0;
    endtask

    // IDLE-only coefficient write; called and returns at a negedge
    task automatic wcoef(input logic [3:0] a, input logic [15:0] d);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        #1;
        chk("wcoef_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        cm[a] = longint'(d);
        @(negedge clk);
        coef_we = 1'b0;
        prev_b2b = 1'b0;
    endtask

    // One sample through the filter; called and returns at a negedge
    task automatic send(input logic [15:0] x, input int hold, input bit mac_we,
                        input bit with_coef, input logic [3:0] ca, input logic [15:0] cd);
        longint unsigned y;
        logic [15:0] expd;
        int n;
        in_valid = 1'b1; data_in = x; out_ready = (hold == 0);
        if (with_coef) begin
            coef_we = 1'b1; coef_addr = ca; coef_data = cd;
            #1;
            chk("coef_pri_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            cm[ca] = longint'(cd);
            @(negedge clk);
            coef_we = 1'b0;
        end
        #1;
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        chk("in_ready_dut2", 64'(in_ready2), 64'(in_ready));
        if (prev_b2b && !with_coef) chk("spacing", 64'(cyc - last_acc), 64'd18);
        last_acc = cyc;
        @(posedge clk);
        xh.push_back(longint'(x));
        y = model_y();
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            if (mac_we && n == 3) begin
                coef_we = 1'b1; coef_addr = 4'($urandom); coef_data = 16'($urandom);
            end
            if (mac_we && n == 4) begin
                coef_we = 1'b0;
                chk("coef_err_pulse", 64'(coef_err), 64'd1);
                chk("coef_err_pulse2", 64'(coef_err2), 64'd1);
            end
            if (mac_we && n == 5) chk("coef_err_clear", 64'(coef_err), 64'd0);
            @(negedge clk);
            n++;
        end
        coef_we = 1'b0;
        expd = 16'(scaled(y, 0));
        chk("latency", 64'(n), 64'd17);
        chk("data_out", 64'(data_out), 64'(expd));
        chk("sat", 64'(sat), 64'((y > 64'hFFFF) ? 1 : 0));
        chk("out_valid2", 64'(out_valid2), 64'd1);
        chk("data_out_sh36", 64'(data_out2), scaled(y, 36));
        chk("sat_sh36", 64'(sat2), 64'(((y >> 36) > 64'hFFFF) ? 1 : 0));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_data", 64'(data_out), 64'(expd));
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_hs_valid", 64'(out_valid), 64'd0);
        prev_b2b = (hold == 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit seen;
        do_reset();

        // Impulse with default coefficients: 1..16 then 0
        send(16'd1, 0, 1'b0, 1'b0, 4'd0, 16'd0);
        for (int i = 0; i < 17; i++) send(16'd0, 0, 1'b0, 1'b0, 4'd0, 16'd0);

        // Step: running sums up to 136, then steady
        do_reset();
        for (int i = 0; i < 18; i++) send(16'd1, 0, 1'b0, 1'b0, 4'd0, 16'd0);

        // Back-pressure, coefficient priority and rejected writes during MAC
        send(16'd7, 5, 1'b0, 1'b0, 4'd0, 16'd0);
        send(16'd3, 0, 1'b0, 1'b1, 4'd2, 16'd100);
        send(16'd9, 0, 1'b1, 1'b0, 4'd0, 16'd0);

        // Randomized samples, holds and coefficient traffic
        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 3) == 0) wcoef(4'($urandom), 16'($urandom_range(0, 300)));
            send(16'($urandom), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)), 4'($urandom), 16'($urandom_range(0, 300)));
        end

        // Saturation with full-scale coefficients and samples
        for (int i = 0; i < 16; i++) wcoef(4'(i), 16'hFFFF);
        for (int i = 0; i < 17; i++) send(16'hFFFF, 0, 1'b0, 1'b0, 4'd0, 16'd0);

        // Reset mid-MAC discards the result and restores defaults
        in_valid = 1'b1; data_in = 16'h1234; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (n < 5) begin @(negedge clk); n++; end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("midmac_rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midmac_no_output", 64'(seen), 64'd0);
        model_reset();
        prev_b2b = 1'b0;
        send(16'd1, 0, 1'b0, 1'b0, 4'd0, 16'd0);
        chk("post_reset_impulse", 64'(data_out), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_serial_ctrl.md
# fir_serial_ctrl

Time-multiplexed controller for the 16-tap FIR datapath: a single multiplier and accumulator evaluate every tap serially instead of sixteen parallel multipliers. It accepts input samples over a valid/ready handshake and stores them in a circular sample buffer. It sequences the tap-by-tap multiply-accumulate, presents each result over a valid/ready handshake, and owns the writable coefficient bank. It sits between the sample source and the output consumer, replacing the fully parallel filter where area matters more than throughput.

## Interface
Parameters:
- TAPS, 16, number of filter taps (power of two).
- DW, 16, sample and output width.
- CW, 16, coefficient width.
- OUT_SHIFT, 0, right shift applied to the accumulator before output.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-low; clears the block on any clk edge where rst=0.
- data_in  in  DW  input sample, unsigned.
- in_valid  in  1  data_in is valid.
- in_ready  out  1  block accepts a sample this cycle.
- data_out  out  DW  filter result, unsigned, saturated.
- out_valid  out  1  data_out is valid.
- out_ready  in  1  consumer accepts data_out.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  log2(TAPS)  coefficient index k.
- coef_data  in  CW  coefficient value.
- coef_err  out  1  one-cycle pulse when a coefficient write is rejected.
- sat  out  1  data_out was clipped; valid while out_valid=1.

## Operation
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - in_ready = !coef_we.
  - On in_valid & in_ready: write data_in to buf[wp], latch base=wp, clear acc, set k=0, increment wp mod TAPS, go to MAC.
- MAC:
  - One tap per cycle: acc += buf[(base-k) mod TAPS] * coef[k].
  - k counts 0..TAPS-1. After k=TAPS-1, go to OUT.
- OUT:
  - out_valid=1. data_out and sat hold stable.
  - On out_ready, go to IDLE.
- Result: y[n] = sum over k of coef[k]*x[n-k]. Samples never written read as 0.
- Arithmetic:
  - Products are CW+DW bits.
  - acc is ACC_W = DW+CW+log2(TAPS) bits, so it never overflows.
  - s = acc >> OUT_SHIFT. If any bit of s above bit DW-1 is set: data_out = all ones and sat=1. Otherwise data_out = s[DW-1:0] and sat=0.
- Coefficient writes:
  - Accepted only in IDLE: coef[coef_addr] <= coef_data at the clock edge.
  - In IDLE, coef_we takes priority over in_valid; no sample is accepted in that cycle.
  - coef_we in MAC or OUT is ignored and coef_err pulses for one cycle. The filter result in progress is unaffected.
- Reset, including mid-MAC or mid-OUT:
  - state=IDLE, wp=0, k=0, acc=0.
  - Every buf entry = 0; coef[k] = k+1.
  - data_out=0, out_valid=0, sat=0, coef_err=0.
  - in_ready=0 while rst=0.
  - Any result in progress is discarded with no output.

## Timing
- Accept at cycle T. MAC cycles run T+1..T+TAPS. out_valid is first high at T+TAPS+1.
- If out_ready=1 at T+TAPS+1, state returns to IDLE at T+TAPS+2, which is the earliest next accept. Minimum sample period is TAPS+2 (18).
- The out_valid/data_out handshake completes on out_valid & out_ready. No combinational path from out_ready to in_ready.
- in_ready depends combinationally on state and coef_we only.
- coef_err is registered and appears the cycle after the rejected strobe.

## Structure
- Shared package fir_pkg holds:
  - TAPS, DW, CW and the ACC_W expression.
  - The state encodings IDLE/MAC/OUT.
  - The default-coefficient rule coef[k]=k+1.
- Sub-module fir_sample_buf: TAPS x DW circular register buffer with one write port and one combinational read port indexed by (base-k) mod TAPS, plus synchronous clear.
- Controller FSM, coefficient bank, multiplier, accumulator and saturation live in fir_serial_ctrl.

## Test plan
- Impulse, default coefficients: input 1 followed by 16 zeros, out_ready=1 -> outputs 1,2,...,16, then 0.
- Step: constant input 1 for 16 samples -> outputs 1,3,6,...,136 (running sums), then 136 steady.
- Saturation: coefficients all 16'hFFFF, constant input 16'hFFFF, OUT_SHIFT=0 -> data_out=16'hFFFF with sat=1. With OUT_SHIFT=36, sat=0 on all outputs.
- Back-pressure and throughput:
  - Hold out_ready=0 for 5 cycles in OUT -> data_out stable and in_ready=0 throughout.
  - With out_ready=1, accept-to-accept spacing = 18 cycles.
- Coefficient handshake:
  - coef_we with in_valid in IDLE -> write lands, in_ready=0 that cycle, sample accepted next cycle.
  - coef_we during MAC -> coef_err pulses and the current output is unchanged.
- Reset mid-MAC: rst=0 at accept+5 -> out_valid never rises. After release, an impulse input yields output 1, showing the buffer and coefficients are back to defaults.
